// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized input, mid-bit sampling, framed byte
// presented on rx_msg together with a single-cycle rx_complete strobe.
`timescale 1ns/1ps
module uart_rx #(
    parameter int unsigned CLK_FREQ     = 50000000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_msg,
    output logic       rx_complete
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       msg_n;
    logic             complete_n;
    logic [1:0]       sync_q;
    logic             rx_s;

    // Metastability guard; resets to the idle line level so reset never looks like a start bit
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx};
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rx_msg      <= 8'h00;
            rx_complete <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            rx_msg      <= msg_n;
            rx_complete <= complete_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CNT_W'(1);
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        msg_n      = rx_msg;
        complete_n = 1'b0;

        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        msg_n      = shift;
                        complete_n = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not be mistaken for a new start bit
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, strobes counted,
// rx_msg compared against hand-computed bytes at the end of each stop bit.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned CPB    = 52;
    localparam int unsigned BIT_NS = CPB * 20;

    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] rx_msg;
    logic       rx_complete;

    int n_vec = 0;
    int n_err = 0;
    int strobes = 0;

    uart_rx #(
        .CLK_FREQ    (50000000),
        .BAUD        (115200),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .rx         (rx),
        .rx_msg     (rx_msg),
        .rx_complete(rx_complete)
    );

    always #10 clk_50M = ~clk_50M;

    // Each high cycle counts once, so a stretched strobe shows up as an extra count
    always @(negedge clk_50M) if (rx_complete) strobes++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(BIT_NS);
        end
        rx = stop_bit;
        #(BIT_NS);
    endtask

    task automatic good_frame(input string tag, input logic [7:0] b);
        int s0;
        s0 = strobes;
        send_frame(b, 1'b1);
        check({tag, "_msg"}, 32'(rx_msg), 32'(b));
        check({tag, "_strobes"}, 32'(strobes - s0), 32'd1);
    endtask

    logic [7:0] edge_vals [4] = '{8'h00, 8'hFF, 8'h80, 8'h01};
    logic [7:0] rnd [20];

    initial begin
        int s0;

        #100;
        check("reset_msg", 32'(rx_msg), 32'h00);
        check("reset_complete", 32'(rx_complete), 32'd0);
        rst = 1'b0;
        #(2 * BIT_NS);

        good_frame("a5", 8'hA5);

        // Reset in the middle of a frame aborts it and clears the output
        s0 = strobes;
        rx = 1'b0;
        #(BIT_NS);
        rx = 1'b1; #(BIT_NS);
        rx = 1'b0; #(BIT_NS);
        rst = 1'b1;
        #100;
        check("midrst_msg", 32'(rx_msg), 32'h00);
        check("midrst_complete", 32'(rx_complete), 32'd0);
        rx  = 1'b1;
        rst = 1'b0;
        #(3 * BIT_NS);
        check("postrst_msg", 32'(rx_msg), 32'h00);
        check("postrst_strobes", 32'(strobes - s0), 32'd0);
        good_frame("after_rst", 8'hC3);

        for (int i = 0; i < 20; i++) rnd[i] = 8'($urandom_range(0, 128));
        s0 = strobes;
        for (int i = 0; i < 20; i++) begin
            send_frame(rnd[i], 1'b1);
            check($sformatf("b2b_%0d", i), 32'(rx_msg), 32'(rnd[i]));
        end
        check("b2b_strobes", 32'(strobes - s0), 32'd20);
        rx = 1'b1;
        #(BIT_NS);

        for (int i = 0; i < 4; i++) begin
            good_frame($sformatf("edge_%0h", edge_vals[i]), edge_vals[i]);
            #(BIT_NS);
        end

        // Short low pulse must be rejected at the mid-start re-sample
        s0 = strobes;
        rx = 1'b0;
        #100;
        rx = 1'b1;
        #(2 * BIT_NS);
        check("glitch_msg", 32'(rx_msg), 32'h01);
        check("glitch_strobes", 32'(strobes - s0), 32'd0);
        good_frame("after_glitch", 8'h3C);
        #(BIT_NS);

        s0 = strobes;
        send_frame(8'h55, 1'b0);
        check("frame_err_msg", 32'(rx_msg), 32'h3C);
        check("frame_err_strobes", 32'(strobes - s0), 32'd0);
        rx = 1'b1;
        #(BIT_NS);
        good_frame("after_ferr", 8'h12);
        #(BIT_NS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
